rmatrix_3x3: RTL and testbench

Converts two plate tilt angles, about the X axis and about the Y axis, into the nine entries of a 3x3 rotation matrix in fixed point. It sits between the angle/control stage and the downstream matrix–vector product units of the ball-and-plate datapath. Each request is a single-cycle `validIn` pulse. The result appears a fixed number of cycles later with a single-cycle `validOut` pulse.

---
 rtl/rmatrix_3x3_if.sv | 25 ++
 rtl/rmatrix_3x3.sv | 212 +++++++++++++++++++++
 tb/tb_rmatrix_3x3.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/rmatrix_3x3_if.sv
// Request/result bundle for rmatrix_3x3.
//   validIn  : one-cycle request strobe, Rx/Ry sampled with it
//   Rx, Ry   : signed Q3.10 tilt angles in half-turns (1024 = 180 deg)
//   R11..R33 : signed Q2.14 rotation matrix entries, row-major
//   validOut : one-cycle strobe marking a fresh matrix
// master = requester (drives angles), slave = rmatrix_3x3.
interface rmatrix_3x3_if;
    logic               validIn;
    logic signed [12:0] Rx;
    logic signed [12:0] Ry;
    logic signed [15:0] R11, R12, R13;
    logic signed [15:0] R21, R22, R23;
    logic signed [15:0] R31, R32, R33;
    logic               validOut;

    modport master (
        output validIn, Rx, Ry,
        input  R11, R12, R13, R21, R22, R23, R31, R32, R33, validOut
    );

    modport slave (
        input  validIn, Rx, Ry,
        output R11, R12, R13, R21, R22, R23, R31, R32, R33, validOut
    );
endinterface

// File: rtl/rmatrix_3x3.sv
// Tilt angles (about X, about Y) to 3x3 rotation matrix R = Ry*Rx in Q2.14.
// Two rotation-mode CORDIC units run side by side for 16 cycles, one
// multiply cycle forms the products, and a final cycle registers the result.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous active-low clear
//   bus   : rmatrix_3x3_if slave (validIn/Rx/Ry in, R11..R33/validOut out)
//
// state  | meaning
// IDLE   | waiting for validIn; captures and clamps both angles
// ROTATE | 16 CORDIC micro-rotations, counter runs 15 down to 0
// MULT   | round sin/cos to Q2.14 and form the matrix products
// DONE   | load outputs, pulse validOut, back to IDLE
module rmatrix_3x3 (
    input  logic         clock,
    input  logic         reset,
    rmatrix_3x3_if.slave bus
);
    typedef enum logic [1:0] {IDLE = 2'd0, ROTATE = 2'd1, MULT = 2'd2, DONE = 2'd3} state_t;

    // x0 = 1/K in Q2.16 so the rotated vector ends at unit length.
    localparam logic signed [17:0] CORDIC_K = 18'sd39797;
    localparam logic signed [15:0] Q14_ONE  = 16'sd16384;
    // z is in 2^-16 half-turn units: 90 deg = 0.5 half-turn = 32768.
    localparam logic signed [18:0] Z_LIMIT  = 19'sd32768;

    function automatic logic signed [18:0] atan_lut(input logic [3:0] i);
        case (i)
            4'd0:    return 19'sd16384;
            4'd1:    return 19'sd9672;
            4'd2:    return 19'sd5110;
            4'd3:    return 19'sd2594;
            4'd4:    return 19'sd1302;
            4'd5:    return 19'sd652;
            4'd6:    return 19'sd326;
            4'd7:    return 19'sd163;
            4'd8:    return 19'sd81;
            4'd9:    return 19'sd41;
            4'd10:   return 19'sd20;
            4'd11:   return 19'sd10;
            4'd12:   return 19'sd5;
            4'd13:   return 19'sd3;
            default: return 19'sd1;
        endcase
    endfunction

    function automatic logic signed [18:0] clamp_angle(input logic signed [12:0] a);
        logic signed [18:0] t;
        t = 19'(a);
        if (a > 13'sd512)
            return Z_LIMIT;
        else if (a < -13'sd512)
            return -Z_LIMIT;
        else
            return t <<< 6;
    endfunction

    // Q2.16 -> Q2.14, round half up, clipped to +/-1.0.
    function automatic logic signed [15:0] round_q14(input logic signed [17:0] v);
        logic signed [17:0] r;
        r = (v + 18'sd2) >>> 2;
        if (r > 18'sd16384)
            return Q14_ONE;
        else if (r < -18'sd16384)
            return -Q14_ONE;
        else
            return r[15:0];
    endfunction

    function automatic logic signed [15:0] qmul(input logic signed [15:0] a,
                                                input logic signed [15:0] b);
        logic signed [31:0] p;
        p = (32'(a) * 32'(b) + 32'sd8192) >>> 14;
        if (p > 32'sd32767)
            return 16'sh7FFF;
        else if (p < -32'sd32768)
            return 16'sh8000;
        else
            return p[15:0];
    endfunction

    function automatic logic signed [15:0] qneg(input logic signed [15:0] a);
        if (a == 16'sh8000)
            return 16'sh7FFF;
        else
            return -a;
    endfunction

    state_t             state;
    logic [3:0]         cnt;
    logic signed [17:0] x_x, y_x, x_y, y_y;
    logic signed [18:0] z_x, z_y;
    logic signed [15:0] p11, p12, p13, p22, p23, p31, p32, p33;

    logic [3:0]         iter;
    logic signed [18:0] atan_i;
    logic signed [17:0] x_x_n, y_x_n, x_y_n, y_y_n;
    logic signed [18:0] z_x_n, z_y_n;
    logic signed [15:0] cx, sx, cy, sy;

    always_comb begin
        iter   = 4'd15 - cnt;
        atan_i = atan_lut(iter);
        // Rotate toward z = 0: positive residual angle means rotate CCW.
        if (!z_x[18]) begin
            x_x_n = x_x - (y_x >>> iter);
            y_x_n = y_x + (x_x >>> iter);
            z_x_n = z_x - atan_i;
        end else begin
            x_x_n = x_x + (y_x >>> iter);
            y_x_n = y_x - (x_x >>> iter);
            z_x_n = z_x + atan_i;
        end
        if (!z_y[18]) begin
            x_y_n = x_y - (y_y >>> iter);
            y_y_n = y_y + (x_y >>> iter);
            z_y_n = z_y - atan_i;
        end else begin
            x_y_n = x_y + (y_y >>> iter);
            y_y_n = y_y - (x_y >>> iter);
            z_y_n = z_y + atan_i;
        end
        cx = round_q14(x_x);
        sx = round_q14(y_x);
        cy = round_q14(x_y);
        sy = round_q14(y_y);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            cnt          <= '0;
            x_x          <= '0;
            y_x          <= '0;
            z_x          <= '0;
            x_y          <= '0;
            y_y          <= '0;
            z_y          <= '0;
            p11          <= '0;
            p12          <= '0;
            p13          <= '0;
            p22          <= '0;
            p23          <= '0;
            p31          <= '0;
            p32          <= '0;
            p33          <= '0;
            bus.R11      <= Q14_ONE;
            bus.R12      <= '0;
            bus.R13      <= '0;
            bus.R21      <= '0;
            bus.R22      <= Q14_ONE;
            bus.R23      <= '0;
            bus.R31      <= '0;
            bus.R32      <= '0;
            bus.R33      <= Q14_ONE;
            bus.validOut <= 1'b0;
        end else begin
            bus.validOut <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.validIn) begin
                        z_x   <= clamp_angle(bus.Rx);
                        z_y   <= clamp_angle(bus.Ry);
                        x_x   <= CORDIC_K;
                        y_x   <= '0;
                        x_y   <= CORDIC_K;
                        y_y   <= '0;
                        cnt   <= 4'd15;
                        state <= ROTATE;
                    end
                end
                ROTATE: begin
                    x_x <= x_x_n;
                    y_x <= y_x_n;
                    z_x <= z_x_n;
                    x_y <= x_y_n;
                    y_y <= y_y_n;
                    z_y <= z_y_n;
                    if (cnt == 4'd0)
                        state <= MULT;
                    else
                        cnt <= cnt - 4'd1;
                end
                MULT: begin
                    p11   <= cy;
                    p12   <= qmul(sy, sx);
                    p13   <= qmul(sy, cx);
                    p22   <= cx;
                    p23   <= qneg(sx);
                    p31   <= qneg(sy);
                    p32   <= qmul(cy, sx);
                    p33   <= qmul(cy, cx);
                    state <= DONE;
                end
                DONE: begin
                    bus.R11      <= p11;
                    bus.R12      <= p12;
                    bus.R13      <= p13;
                    bus.R21      <= '0;
                    bus.R22      <= p22;
                    bus.R23      <= p23;
                    bus.R31      <= p31;
                    bus.R32      <= p32;
                    bus.R33      <= p33;
                    bus.validOut <= 1'b1;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_rmatrix_3x3.sv
// Randomised scoreboard bench for rmatrix_3x3: the driver pushes the ideal
// matrix (real-valued trig) for every request that should be accepted, and a
// monitor pops and compares on each validOut.
module tb_rmatrix_3x3;
    localparam real PI  = 3.14159265358979;
    localparam int  TOL = 8;

    logic clock = 1'b0;
    logic reset = 1'b0;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   pulses = 0;
    int   last_acc = -1000;
    int   q_edge[$];
    int   q_r[$];
    int   last_exp[9] = '{16384, 0, 0, 0, 16384, 0, 0, 0, 16384};
    string names[9] = '{"R11", "R12", "R13", "R21", "R22", "R23", "R31", "R32", "R33"};

    rmatrix_3x3_if bus ();

    rmatrix_3x3 dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string name, input int got, input int exp, input int tol);
        int d;
        d = got - exp;
        n_cmp++;
        if (d > tol || d < -tol) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at cycle %0d", name, got, exp, tol, cyc);
        end
    endtask

    function automatic int q14(input real v);
        return $rtoi($floor(v * 16384.0 + 0.5));
    endfunction

    function automatic real to_rad(input int a);
        int c;
        c = (a > 512) ? 512 : ((a < -512) ? -512 : a);
        return real'(c) * PI / 1024.0;
    endfunction

    task automatic push_model(input int ax, input int ay, input int edge_n);
        real cx, sx, cy, sy;
        cx = $cos(to_rad(ax));
        sx = $sin(to_rad(ax));
        cy = $cos(to_rad(ay));
        sy = $sin(to_rad(ay));
        q_edge.push_back(edge_n);
        q_r.push_back(q14(cy));
        q_r.push_back(q14(sy * sx));
        q_r.push_back(q14(sy * cx));
        q_r.push_back(0);
        q_r.push_back(q14(cx));
        q_r.push_back(q14(-sx));
        q_r.push_back(q14(-sy));
        q_r.push_back(q14(cy * sx));
        q_r.push_back(q14(cy * cx));
    endtask

    // Holds validIn for 'width' cycles; a request is taken only when the
    // previous one has fully finished (19-cycle occupancy).
    task automatic send(input logic signed [12:0] ax, input logic signed [12:0] ay, input int width);
        int edge_n;
        for (int w = 0; w < width; w++) begin
            @(negedge clock);
            bus.validIn = 1'b1;
            bus.Rx      = ax;
            bus.Ry      = ay;
            edge_n      = cyc + 1;
            if (edge_n >= last_acc + 19) begin
                last_acc = edge_n;
                push_model(int'(ax), int'(ay), edge_n);
            end
        end
        @(negedge clock);
        bus.validIn = 1'b0;
    endtask

    task automatic check_identity(input string tag);
        chk({tag, "_R11"}, int'(bus.R11), 16384, 0);
        chk({tag, "_R12"}, int'(bus.R12), 0, 0);
        chk({tag, "_R13"}, int'(bus.R13), 0, 0);
        chk({tag, "_R21"}, int'(bus.R21), 0, 0);
        chk({tag, "_R22"}, int'(bus.R22), 16384, 0);
        chk({tag, "_R23"}, int'(bus.R23), 0, 0);
        chk({tag, "_R31"}, int'(bus.R31), 0, 0);
        chk({tag, "_R32"}, int'(bus.R32), 0, 0);
        chk({tag, "_R33"}, int'(bus.R33), 16384, 0);
        chk({tag, "_validOut"}, int'(bus.validOut), 0, 0);
    endtask

    // Monitor
    always @(negedge clock) begin
        int got[9];
        int e_edge;
        int e;
        if (reset && bus.validOut) begin
            pulses++;
            if (q_edge.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL unexpected_validOut: got pulse at cycle %0d expected none", cyc);
            end else begin
                got = '{int'(bus.R11), int'(bus.R12), int'(bus.R13),
                        int'(bus.R21), int'(bus.R22), int'(bus.R23),
                        int'(bus.R31), int'(bus.R32), int'(bus.R33)};
                e_edge = q_edge.pop_front();
                chk("latency", cyc - e_edge, 18, 0);
                for (int k = 0; k < 9; k++) begin
                    e = q_r.pop_front();
                    last_exp[k] = e;
                    chk(names[k], got[k], e, (k == 3) ? 0 : TOL);
                end
            end
        end
    end

    initial begin
        logic signed [12:0] ax, ay;
        int v;
        bus.validIn = 1'b0;
        bus.Rx      = '0;
        bus.Ry      = '0;

        #100;
        check_identity("in_reset");
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check_identity("after_reset");
        repeat (30) @(negedge clock);
        chk("idle_no_validOut", pulses, 0, 0);

        // Directed points
        send(13'sd0, 13'sd0, 1);
        repeat (25) @(negedge clock);
        send(13'h1F55, 13'h00AA, 1);
        repeat (25) @(negedge clock);
        send(13'sd0, 13'h0400, 1);
        repeat (25) @(negedge clock);
        send(13'h1C00, 13'h0E00, 1);
        repeat (25) @(negedge clock);

        // Second request five edges after the first must be dropped
        send(13'sd100, 13'sd200, 1);
        repeat (3) @(negedge clock);
        send(-13'sd300, 13'sd50, 1);
        repeat (25) @(negedge clock);

        // validIn held high starts a single computation
        send(13'sd256, -13'sd400, 5);
        repeat (25) @(negedge clock);

        // Reset mid-computation aborts, then a fresh request completes
        send(13'sd333, 13'sd444, 1);
        repeat (10) @(negedge clock);
        reset = 1'b0;
        q_edge.delete();
        q_r.delete();
        last_acc = -1000;
        last_exp = '{16384, 0, 0, 0, 16384, 0, 0, 0, 16384};
        #1;
        check_identity("abort");
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        repeat (25) @(negedge clock);
        send(-13'sd222, 13'sd111, 1);
        repeat (25) @(negedge clock);

        // Random requests with random spacing; the model decides acceptance
        for (int n = 0; n < 40; n++) begin
            v  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1024)) - 512
                                             : int'($urandom_range(0, 8191)) - 4096;
            ax = 13'(v);
            v  = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 1024)) - 512
                                             : int'($urandom_range(0, 8191)) - 4096;
            ay = 13'(v);
            send(ax, ay, int'($urandom_range(1, 3)));
            repeat ($urandom_range(0, 24)) @(negedge clock);
        end

        repeat (40) @(negedge clock);
        chk("queue_drained", q_edge.size(), 0, 0);
        chk("hold_R11", int'(bus.R11), last_exp[0], TOL);
        chk("hold_R13", int'(bus.R13), last_exp[2], TOL);
        chk("hold_R32", int'(bus.R32), last_exp[7], TOL);
        chk("hold_R33", int'(bus.R33), last_exp[8], TOL);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
